axil_reg_arbiter: RTL and testbench
===================================

AXIL_REG_ARBITER -- requirements
Module: axil_reg_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2, number of requesters sharing the AXI4-Lite slave (legal 2..4).
REQ-002 SHALL have parameter C_M_AXI_ADDR_WIDTH, default 4, byte address width on the master port.
REQ-003 SHALL have parameter C_M_AXI_DATA_WIDTH, default 32, data width (fixed 32; other values are unsupported).
REQ-004 SHALL have port ACLK, input, 1, sole clock; all logic on its rising edge.
REQ-005 SHALL have port ARESET, input, 1, reset; asynchronous and active-high.
REQ-006 SHALL have port req, input, NUM_REQ, per-requester request level; held until the matching ack.
REQ-007 SHALL have port req_we, input, NUM_REQ, per-requester access type: 1 = write, 0 = read.
REQ-008 SHALL have port req_addr, input, NUM_REQ*C_M_AXI_ADDR_WIDTH, per-requester byte address.
REQ-009 SHALL have port req_wdata, input, NUM_REQ*32, per-requester write data.
REQ-010 SHALL have port ack, output, NUM_REQ, one-cycle completion pulse to the granted requester.
REQ-011 SHALL have port rsp_rdata, output, 32, read data, valid with ack.
REQ-012 SHALL have port rsp_resp, output, 2, BRESP or RRESP of the completed access, valid with ack.
REQ-013 SHALL have the AXI4-Lite master ports M_AXI_AWADDR, AWPROT, AWVALID, AWREADY, WDATA, WSTRB, WVALID, WREADY, BRESP, BVALID, BREADY, ARADDR, ARPROT, ARVALID, ARREADY, RDATA, RRESP, RVALID and RREADY, with standard directions and widths.

Function
REQ-014 SHALL implement the states IDLE, WR, WR_RESP, RD_ADDR, RD_DATA and DONE.
REQ-015 In IDLE with any req bit set, SHALL grant one requester, register its address, data and we, and move to WR or RD_ADDR on the next cycle.
REQ-016 Arbitration SHALL be round-robin: the search starts at index last_grant+1 mod NUM_REQ; last_grant resets to NUM_REQ-1, so requester 0 wins first.
REQ-017 In WR, SHALL assert AWVALID and WVALID together and deassert each independently on its own handshake; it SHALL move to WR_RESP once both handshakes have occurred, including when both complete in the same cycle.
REQ-018 In WR_RESP, SHALL assert BREADY; on BVALID it SHALL capture BRESP and go to DONE.
REQ-019 In RD_ADDR, SHALL assert ARVALID until ARREADY, then go to RD_DATA.
REQ-020 In RD_DATA, SHALL assert RREADY; on RVALID it SHALL capture RDATA and RRESP and go to DONE.
REQ-021 In DONE, SHALL pulse ack[grant] for exactly one cycle, hold rsp_rdata and rsp_resp stable until the next DONE, update last_grant, and return to IDLE.
REQ-022 Minimum request-to-ack latency SHALL be 4 cycles with a zero-wait slave; the next grant SHALL occur no earlier than the cycle after DONE.
REQ-023 WSTRB SHALL be 4'hF, AWPROT and ARPROT SHALL be 3'b000, and the address SHALL pass through unmodified (no alignment check).
REQ-024 A nonzero response SHALL be forwarded on rsp_resp without retry.
REQ-025 A req bit that drops before its grant SHALL be ignored; a req bit that drops after its grant SHALL NOT abort the transaction.
REQ-026 rsp_rdata SHALL be left unchanged after a write.

Reset
REQ-027 While ARESET is high, SHALL drive state to IDLE; all VALID and READY outputs, ack, rsp_rdata, rsp_resp and the address/data registers to 0; and last_grant to NUM_REQ-1.
REQ-028 Reset asserted mid-transaction SHALL abandon the access with no ack; the slave-side consequence is outside this block's scope.

Structure
REQ-029 Package axil_arb_pkg SHALL hold the state enum, the AXI response constants (OKAY=2'b00, SLVERR=2'b10) and the fixed WSTRB/PROT constants.
REQ-030 The round-robin selector SHALL be a sub-module rr_arbiter (inputs: req, last_grant, enable; output: one-hot grant plus index); the FSM and registers live in the top module.

Verification
REQ-031 Reset, then req=01 write addr 0x0, data 0x00000001 -> AW/W at 0x0, ack=01 after 4 cycles, rsp_resp=00.
REQ-032 Write 0x1..0x4 to 0x0, 0x4, 0x8 and 0xC, then read the same addresses -> rsp_rdata = 0x1, 0x2, 0x3 and 0x4 in order.
REQ-033 req=11 held continuously, both writes -> grant order 0,1,0,1; no requester receives two consecutive acks.
REQ-034 Slave asserts WREADY 3 cycles before AWREADY -> single W handshake, WVALID low while AWVALID is still high, one ack.
REQ-035 Slave returns RRESP=2'b10 on a read of 0x8 -> rsp_resp=10, ack pulsed, FSM back in IDLE.
REQ-036 ARESET asserted during RD_DATA -> no ack, all outputs 0 next cycle; a new req after release is served normally.

Source files
------------

// File: rtl/axil_arb_pkg.sv
// rtl/axil_arb_pkg.sv - shared types and constants for the AXI4-Lite register arbiter
// Holds the controller state encoding, AXI response codes and the fixed
// write-strobe / protection values driven onto the master port.
package axil_arb_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR      = 3'd1,
        WR_RESP = 3'd2,
        RD_ADDR = 3'd3,
        RD_DATA = 3'd4,
        DONE    = 3'd5
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [3:0] AXI_WSTRB = 4'hF;
    localparam logic [2:0] AXI_PROT  = 3'b000;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin requester selector
// Ports:
//   i_req        per-requester request levels
//   i_last_grant index of the previously served requester
//   i_enable     selection is only produced while enabled
//   o_grant      one-hot grant (all zero when nothing is selected)
//   o_grant_idx  binary index of the granted requester
module rr_arbiter
    import axil_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_last_grant,
    input  logic               i_enable,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_grant_idx
);

    // Walk the requesters starting one past the last winner, wrapping
    // around, and take the first active one.
    always_comb begin
        logic             found;
        logic [IDX_W-1:0] cand;
        o_grant     = '0;
        o_grant_idx = '0;
        found       = 1'b0;
        cand        = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = IDX_W'((int'(i_last_grant) + i) % NUM_REQ);
            if (i_enable && !found && i_req[cand]) begin
                found         = 1'b1;
                o_grant[cand] = 1'b1;
                o_grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/axil_reg_arbiter.sv
// rtl/axil_reg_arbiter.sv - shares one AXI4-Lite slave among several register requesters
// Ports:
//   ACLK, ARESET                  clock, asynchronous active-high reset
//   req/req_we/req_addr/req_wdata per-requester access request, held until ack
//   ack                           one-cycle completion pulse to the served requester
//   rsp_rdata/rsp_resp            read data and response of the last completed access
//   M_AXI_*                       AXI4-Lite master port
module axil_reg_arbiter
    import axil_arb_pkg::*;
#(
    parameter int NUM_REQ            = 2,
    parameter int C_M_AXI_ADDR_WIDTH = 4,
    parameter int C_M_AXI_DATA_WIDTH = 32
) (
    input  logic                                   ACLK,
    input  logic                                   ARESET,
    input  logic [NUM_REQ-1:0]                     req,
    input  logic [NUM_REQ-1:0]                     req_we,
    input  logic [NUM_REQ*C_M_AXI_ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ*C_M_AXI_DATA_WIDTH-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]                     ack,
    output logic [C_M_AXI_DATA_WIDTH-1:0]          rsp_rdata,
    output logic [1:0]                             rsp_resp,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]          M_AXI_AWADDR,
    output logic [2:0]                             M_AXI_AWPROT,
    output logic                                   M_AXI_AWVALID,
    input  logic                                   M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]          M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]        M_AXI_WSTRB,
    output logic                                   M_AXI_WVALID,
    input  logic                                   M_AXI_WREADY,
    input  logic [1:0]                             M_AXI_BRESP,
    input  logic                                   M_AXI_BVALID,
    output logic                                   M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]          M_AXI_ARADDR,
    output logic [2:0]                             M_AXI_ARPROT,
    output logic                                   M_AXI_ARVALID,
    input  logic                                   M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]          M_AXI_RDATA,
    input  logic [1:0]                             M_AXI_RRESP,
    input  logic                                   M_AXI_RVALID,
    output logic                                   M_AXI_RREADY
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int AW    = C_M_AXI_ADDR_WIDTH;
    localparam int DW    = C_M_AXI_DATA_WIDTH;

    state_t             r_state;
    state_t             w_state_next;
    logic [NUM_REQ-1:0] r_grant;
    logic [IDX_W-1:0]   r_grant_idx;
    logic [IDX_W-1:0]   r_last_grant;
    logic               r_we;
    logic [AW-1:0]      r_addr;
    logic [DW-1:0]      r_wdata;
    logic [DW-1:0]      r_rdata;
    logic [1:0]         r_resp;
    logic               r_aw_done;
    logic               r_w_done;

    logic [NUM_REQ-1:0] w_arb_grant;
    logic [IDX_W-1:0]   w_arb_idx;
    logic               w_arb_en;
    logic               w_aw_hs;
    logic               w_w_hs;

    assign w_arb_en = (r_state == IDLE);

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .i_req        (req),
        .i_last_grant (r_last_grant),
        .i_enable     (w_arb_en),
        .o_grant      (w_arb_grant),
        .o_grant_idx  (w_arb_idx)
    );

    assign w_aw_hs = M_AXI_AWVALID & M_AXI_AWREADY;
    assign w_w_hs  = M_AXI_WVALID & M_AXI_WREADY;

    assign M_AXI_AWADDR = r_addr;
    assign M_AXI_ARADDR = r_addr;
    assign M_AXI_WDATA  = r_wdata;
    assign M_AXI_WSTRB  = AXI_WSTRB;
    assign M_AXI_AWPROT = AXI_PROT;
    assign M_AXI_ARPROT = AXI_PROT;
    assign rsp_rdata    = r_rdata;
    assign rsp_resp     = r_resp;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        M_AXI_AWVALID = 1'b0;
        M_AXI_WVALID  = 1'b0;
        M_AXI_BREADY  = 1'b0;
        M_AXI_ARVALID = 1'b0;
        M_AXI_RREADY  = 1'b0;
        ack           = '0;
        case (r_state)
            IDLE: begin
                if (|w_arb_grant) begin
                    w_state_next = req_we[w_arb_idx] ? WR : RD_ADDR;
                end
            end
            WR: begin
                // AW and W are independent channels; each drops after its
                // own handshake and we leave once both have been accepted.
                M_AXI_AWVALID = !r_aw_done;
                M_AXI_WVALID  = !r_w_done;
                if ((r_aw_done || M_AXI_AWREADY) && (r_w_done || M_AXI_WREADY)) begin
                    w_state_next = WR_RESP;
                end
            end
            WR_RESP: begin
                M_AXI_BREADY = 1'b1;
                if (M_AXI_BVALID) begin
                    w_state_next = DONE;
                end
            end
            RD_ADDR: begin
                M_AXI_ARVALID = 1'b1;
                if (M_AXI_ARREADY) begin
                    w_state_next = RD_DATA;
                end
            end
            RD_DATA: begin
                M_AXI_RREADY = 1'b1;
                if (M_AXI_RVALID) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                ack          = r_grant;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_grant      <= '0;
            r_grant_idx  <= '0;
            r_last_grant <= IDX_W'(NUM_REQ - 1);
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rdata      <= '0;
            r_resp       <= RESP_OKAY;
            r_aw_done    <= 1'b0;
            r_w_done     <= 1'b0;
        end else begin
            // Handshake flags only live while in WR; cleared on exit.
            r_aw_done <= (w_state_next == WR) && (r_aw_done || w_aw_hs);
            r_w_done  <= (w_state_next == WR) && (r_w_done || w_w_hs);
            case (r_state)
                IDLE: begin
                    if (|w_arb_grant) begin
                        r_grant     <= w_arb_grant;
                        r_grant_idx <= w_arb_idx;
                        r_we        <= req_we[w_arb_idx];
                        r_addr      <= req_addr[w_arb_idx*AW +: AW];
                        r_wdata     <= req_wdata[w_arb_idx*DW +: DW];
                    end
                end
                WR_RESP: begin
                    if (M_AXI_BVALID) begin
                        r_resp <= M_AXI_BRESP;
                    end
                end
                RD_DATA: begin
                    // Read data is only ever refreshed by a read, so a write
                    // leaves the previous read result visible.
                    if (M_AXI_RVALID && !r_we) begin
                        r_rdata <= M_AXI_RDATA;
                        r_resp  <= M_AXI_RRESP;
                    end
                end
                DONE: begin
                    r_last_grant <= r_grant_idx;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axil_reg_arbiter.sv
// tb/tb_axil_reg_arbiter.sv - directed-vector bench for axil_reg_arbiter
module tb_axil_reg_arbiter;

    localparam int NR = 2;
    localparam int AW = 4;

    logic            ACLK = 1'b0;
    logic            ARESET = 1'b1;
    logic [NR-1:0]   req = '0;
    logic [NR-1:0]   req_we = '0;
    logic [NR*AW-1:0] req_addr = '0;
    logic [NR*32-1:0] req_wdata = '0;
    logic [NR-1:0]   ack;
    logic [31:0]     rsp_rdata;
    logic [1:0]      rsp_resp;
    logic [AW-1:0]   M_AXI_AWADDR;
    logic [2:0]      M_AXI_AWPROT;
    logic            M_AXI_AWVALID;
    logic            M_AXI_AWREADY = 1'b0;
    logic [31:0]     M_AXI_WDATA;
    logic [3:0]      M_AXI_WSTRB;
    logic            M_AXI_WVALID;
    logic            M_AXI_WREADY = 1'b0;
    logic [1:0]      M_AXI_BRESP = 2'b00;
    logic            M_AXI_BVALID = 1'b0;
    logic            M_AXI_BREADY;
    logic [AW-1:0]   M_AXI_ARADDR;
    logic [2:0]      M_AXI_ARPROT;
    logic            M_AXI_ARVALID;
    logic            M_AXI_ARREADY = 1'b0;
    logic [31:0]     M_AXI_RDATA = '0;
    logic [1:0]      M_AXI_RRESP = 2'b00;
    logic            M_AXI_RVALID = 1'b0;
    logic            M_AXI_RREADY;

    axil_reg_arbiter #(
        .NUM_REQ            (NR),
        .C_M_AXI_ADDR_WIDTH (AW),
        .C_M_AXI_DATA_WIDTH (32)
    ) dut (
        .ACLK          (ACLK),
        .ARESET        (ARESET),
        .req           (req),
        .req_we        (req_we),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .ack           (ack),
        .rsp_rdata     (rsp_rdata),
        .rsp_resp      (rsp_resp),
        .M_AXI_AWADDR  (M_AXI_AWADDR),
        .M_AXI_AWPROT  (M_AXI_AWPROT),
        .M_AXI_AWVALID (M_AXI_AWVALID),
        .M_AXI_AWREADY (M_AXI_AWREADY),
        .M_AXI_WDATA   (M_AXI_WDATA),
        .M_AXI_WSTRB   (M_AXI_WSTRB),
        .M_AXI_WVALID  (M_AXI_WVALID),
        .M_AXI_WREADY  (M_AXI_WREADY),
        .M_AXI_BRESP   (M_AXI_BRESP),
        .M_AXI_BVALID  (M_AXI_BVALID),
        .M_AXI_BREADY  (M_AXI_BREADY),
        .M_AXI_ARADDR  (M_AXI_ARADDR),
        .M_AXI_ARPROT  (M_AXI_ARPROT),
        .M_AXI_ARVALID (M_AXI_ARVALID),
        .M_AXI_ARREADY (M_AXI_ARREADY),
        .M_AXI_RDATA   (M_AXI_RDATA),
        .M_AXI_RRESP   (M_AXI_RRESP),
        .M_AXI_RVALID  (M_AXI_RVALID),
        .M_AXI_RREADY  (M_AXI_RREADY)
    );

    always #5 ACLK = ~ACLK;

    // Slave model: acts on the falling edge so everything it drives is
    // stable at the next rising edge. Handshakes are recognised when both
    // sides are high at the falling edge, i.e. for the coming rising edge.
    logic [31:0] mem [4] = '{default: 32'h0};
    int          aw_wait = 0, w_wait = 0, r_wait = 0;
    int          aw_cnt = 0, w_cnt = 0, r_cnt = 0;
    int          aw_hs = 0, w_hs = 0, ar_hs = 0, wlow_cnt = 0;
    logic        err_en = 1'b0;
    logic [AW-1:0] err_addr = '0;
    logic        got_aw = 0, got_w = 0, got_ar = 0, b_clear = 0, r_clear = 0;
    logic [AW-1:0] aw_addr = '0, ar_addr = '0;
    logic [31:0] w_data = '0;
    logic [3:0]  w_strb = '0;
    logic [2:0]  aw_prot = '1, ar_prot = '1;

    always @(negedge ACLK) begin
        if (ARESET) begin
            M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_ARREADY = 0;
            M_AXI_BVALID = 0; M_AXI_RVALID = 0;
            got_aw = 0; got_w = 0; got_ar = 0; b_clear = 0; r_clear = 0;
            aw_cnt = 0; w_cnt = 0; r_cnt = 0;
        end else begin
            if (b_clear) begin M_AXI_BVALID = 0; b_clear = 0; end
            if (got_aw && got_w && !M_AXI_BVALID) begin
                mem[aw_addr[3:2]] = w_data;
                M_AXI_BVALID = 1; M_AXI_BRESP = 2'b00;
                got_aw = 0; got_w = 0;
            end
            if (M_AXI_BVALID && M_AXI_BREADY) b_clear = 1;

            if (r_clear) begin M_AXI_RVALID = 0; r_clear = 0; end
            if (got_ar && !M_AXI_RVALID) begin
                if (r_cnt >= r_wait) begin
                    M_AXI_RVALID = 1;
                    M_AXI_RDATA  = mem[ar_addr[3:2]];
                    M_AXI_RRESP  = (err_en && ar_addr == err_addr) ? 2'b10 : 2'b00;
                    got_ar = 0; r_cnt = 0;
                end else r_cnt++;
            end
            if (M_AXI_RVALID && M_AXI_RREADY) r_clear = 1;

            if (M_AXI_AWVALID) begin
                if (aw_cnt >= aw_wait) begin
                    M_AXI_AWREADY = 1; aw_addr = M_AXI_AWADDR; aw_prot = M_AXI_AWPROT;
                    got_aw = 1; aw_hs++; aw_cnt = 0;
                end else begin M_AXI_AWREADY = 0; aw_cnt++; end
            end else begin M_AXI_AWREADY = 0; aw_cnt = 0; end

            if (M_AXI_WVALID) begin
                if (w_cnt >= w_wait) begin
                    M_AXI_WREADY = 1; w_data = M_AXI_WDATA; w_strb = M_AXI_WSTRB;
                    got_w = 1; w_hs++; w_cnt = 0;
                end else begin M_AXI_WREADY = 0; w_cnt++; end
            end else begin M_AXI_WREADY = 0; w_cnt = 0; end

            if (M_AXI_ARVALID) begin
                M_AXI_ARREADY = 1; ar_addr = M_AXI_ARADDR; ar_prot = M_AXI_ARPROT;
                got_ar = 1; ar_hs++;
            end else M_AXI_ARREADY = 0;

            if (M_AXI_AWVALID && !M_AXI_WVALID) wlow_cnt++;
        end
    end

    int n_vec = 0, n_miss = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge ACLK);
        #1;
    endtask

    // Presents one access on requester idx, waits for its ack, drops the
    // request and steps into the following IDLE cycle. lat counts the cycle
    // the request is presented in as cycle 1.
    task automatic do_access(input int idx, input logic we, input logic [AW-1:0] addr,
                             input logic [31:0] wd, output logic [NR-1:0] ack_o,
                             output logic [31:0] rd, output logic [1:0] rs, output int lat);
        req_we[idx] = we;
        req_addr[idx*AW +: AW] = addr;
        req_wdata[idx*32 +: 32] = wd;
        req[idx] = 1'b1;
        lat = 1;
        ack_o = '0;
        while (lat < 60 && ack_o == 0) begin
            tick();
            lat++;
            ack_o = ack;
        end
        req[idx] = 1'b0;
        rd = rsp_rdata;
        rs = rsp_resp;
        check_eq("ack_seen", 32'(ack_o != 0), 32'd1);
        tick();
    endtask

    logic [NR-1:0] a;
    logic [31:0]   rd;
    logic [1:0]    rs;
    int            lat;
    int            base_aw, base_w, base_wl, nack;
    logic [NR-1:0] order [4];
    logic          found;
    logic [31:0]   wvals [4];

    initial begin
        // Reset state
        tick(); tick();
        check_eq("rst_ack", 32'(ack), 32'd0);
        check_eq("rst_valid_ready", 32'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY,
                                         M_AXI_ARVALID, M_AXI_RREADY}), 32'd0);
        check_eq("rst_rdata", rsp_rdata, 32'd0);
        check_eq("rst_resp", 32'(rsp_resp), 32'd0);
        check_eq("rst_addr_data", 32'(M_AXI_AWADDR) | M_AXI_WDATA, 32'd0);
        ARESET = 1'b0;
        tick();

        // First write from requester 0
        base_wl = wlow_cnt;
        do_access(0, 1'b1, 4'h0, 32'h1, a, rd, rs, lat);
        check_eq("w1_ack", 32'(a), 32'h1);
        check_eq("w1_lat", 32'(lat), 32'd4);
        check_eq("w1_resp", 32'(rs), 32'd0);
        check_eq("w1_awaddr", 32'(aw_addr), 32'h0);
        check_eq("w1_wdata", w_data, 32'h1);
        check_eq("w1_wstrb", 32'(w_strb), 32'hF);
        check_eq("w1_awprot", 32'(aw_prot), 32'd0);
        check_eq("w1_no_wlow", 32'(wlow_cnt - base_wl), 32'd0);

        // Write 1..4 to 0,4,8,C then read back
        wvals = '{32'h1, 32'h2, 32'h3, 32'h4};
        for (int i = 0; i < 4; i++) begin
            do_access(0, 1'b1, AW'(i * 4), wvals[i], a, rd, rs, lat);
            check_eq($sformatf("wr%0d_ack", i), 32'(a), 32'h1);
        end
        for (int i = 0; i < 4; i++) begin
            do_access(0, 1'b0, AW'(i * 4), 32'h0, a, rd, rs, lat);
            check_eq($sformatf("rd%0d_data", i), rd, wvals[i]);
            check_eq($sformatf("rd%0d_lat", i), 32'(lat), 32'd4);
        end
        check_eq("rd_araddr", 32'(ar_addr), 32'hC);
        check_eq("rd_arprot", 32'(ar_prot), 32'd0);
        do_access(0, 1'b1, 4'h0, 32'h55, a, rd, rs, lat);
        check_eq("rdata_kept_after_wr", rd, 32'h4);

        // Round robin: make requester 1 the last winner, then hold both
        do_access(1, 1'b0, 4'h4, 32'h0, a, rd, rs, lat);
        check_eq("r1_ack", 32'(a), 32'h2);
        check_eq("r1_data", rd, 32'h2);
        req_we = 2'b11;
        req_addr = {4'hC, 4'h8};
        req_wdata = {32'hB1, 32'hA0};
        req = 2'b11;
        nack = 0;
        for (int c = 0; c < 100 && nack < 4; c++) begin
            tick();
            if (ack != 0) begin
                order[nack] = ack;
                nack++;
                if (nack == 4) req = '0;
            end
        end
        tick();
        check_eq("rr_nack", 32'(nack), 32'd4);
        check_eq("rr_0", 32'(order[0]), 32'h1);
        check_eq("rr_1", 32'(order[1]), 32'h2);
        check_eq("rr_2", 32'(order[2]), 32'h1);
        check_eq("rr_3", 32'(order[3]), 32'h2);
        check_eq("rr_mem8", mem[2], 32'hA0);
        check_eq("rr_memC", mem[3], 32'hB1);

        // W accepted 3 cycles before AW
        aw_wait = 3;
        base_aw = aw_hs; base_w = w_hs; base_wl = wlow_cnt;
        do_access(0, 1'b1, 4'hC, 32'h44, a, rd, rs, lat);
        aw_wait = 0;
        check_eq("skew_ack", 32'(a), 32'h1);
        check_eq("skew_lat", 32'(lat), 32'd7);
        check_eq("skew_aw_hs", 32'(aw_hs - base_aw), 32'd1);
        check_eq("skew_w_hs", 32'(w_hs - base_w), 32'd1);
        check_eq("skew_wlow_seen", 32'(wlow_cnt != base_wl), 32'd1);
        check_eq("skew_mem", mem[3], 32'h44);

        // Error response forwarded
        err_en = 1'b1; err_addr = 4'h8;
        do_access(1, 1'b0, 4'h8, 32'h0, a, rd, rs, lat);
        err_en = 1'b0;
        check_eq("err_ack", 32'(a), 32'h2);
        check_eq("err_resp", 32'(rs), 32'h2);
        check_eq("err_data", rd, 32'hA0);
        check_eq("err_ack_pulse", 32'(ack), 32'd0);
        check_eq("err_idle", 32'({M_AXI_ARVALID, M_AXI_RREADY, M_AXI_AWVALID}), 32'd0);
        do_access(0, 1'b0, 4'h0, 32'h0, a, rd, rs, lat);
        check_eq("after_err_lat", 32'(lat), 32'd4);
        check_eq("after_err_resp", 32'(rs), 32'd0);

        // Reset during RD_DATA
        do_access(1, 1'b0, 4'h8, 32'h0, a, rd, rs, lat);
        r_wait = 5;
        req_we[0] = 1'b0; req_addr[0 +: AW] = 4'h4; req[0] = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            tick();
            found = M_AXI_RREADY;
        end
        check_eq("rst_mid_reach_rd", 32'(found), 32'd1);
        ARESET = 1'b1;
        req = '0;
        tick();
        check_eq("rst_mid_ack", 32'(ack), 32'd0);
        check_eq("rst_mid_valid", 32'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY,
                                       M_AXI_ARVALID, M_AXI_RREADY}), 32'd0);
        check_eq("rst_mid_rdata", rsp_rdata, 32'd0);
        check_eq("rst_mid_resp", 32'(rsp_resp), 32'd0);
        tick();
        ARESET = 1'b0;
        r_wait = 0;
        tick();
        do_access(1, 1'b0, 4'h4, 32'h0, a, rd, rs, lat);
        check_eq("post_rst_ack", 32'(a), 32'h2);
        check_eq("post_rst_data", rd, 32'h2);
        check_eq("post_rst_lat", 32'(lat), 32'd4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
